// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder sequencer around a registered-carry 1-bit adder cell
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] psum_nxt;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             carry_nxt;
    logic             ha1_s;
    logic             ha1_c;
    logic             ha2_s;
    logic             ha2_c;
    logic             accept;
    logic             step;

    // Adder cell: two cascaded half adders, their carries ORed.
    assign ha1_s     = opa[0] ^ opb[0];
    assign ha1_c     = opa[0] & opb[0];
    assign ha2_s     = ha1_s ^ carry;
    assign ha2_c     = ha1_s & carry;
    assign carry_nxt = ha1_c | ha2_c;

    // New sum bit enters at the MSB so that after WIDTH steps bit 0 sits at the LSB.
    if (WIDTH == 1) begin : g_w1
        assign psum_nxt = ha2_s;
    end else begin : g_wn
        assign psum_nxt = {ha2_s, psum[WIDTH-1:1]};
    end

    assign accept = (state == IDLE) && start && !clr;
    assign step   = (state == RUN) && !clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = RUN;
                RUN:     if (cnt == LAST) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:  busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Result registers move only on the step that completes the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa   <= '0;
            opb   <= '0;
            psum  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            opa   <= a;
            opb   <= b;
            psum  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
        end else if (step) begin
            opa   <= opa >> 1;
            opb   <= opb >> 1;
            psum  <= psum_nxt;
            carry <= carry_nxt;
            cnt   <= cnt + CW'(1);
            if (cnt == LAST) begin
                sum  <= psum_nxt;
                cout <= carry_nxt;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl (WIDTH=8 and WIDTH=1)
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, clr8, start1, clr1;
    logic [7:0] a8, b8, sum8;
    logic [0:0] a1, b1, sum1;
    logic       busy8, done8, cout8, busy1, done1, cout1;

    int tests = 0;
    int fails = 0;
    logic [7:0] ps8 = 8'h00;
    logic       pc8 = 1'b0;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .clr(clr8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .clr(clr1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 operation; result expected from plain integer addition.
    task automatic op8(input logic [7:0] xa, input logic [7:0] xb, input bit poke);
        logic [8:0] exp_total;
        int n;
        exp_total = {1'b0, xa} + {1'b0, xb};
        a8 = xa; b8 = xb; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
        chk("busy_accept", {31'd0, busy8}, 32'd1);
        n = 0;
        while (done8 !== 1'b1 && n < 40) begin
            chk("hold_result", {23'd0, cout8, sum8}, {23'd0, pc8, ps8});
            chk("busy_run", {31'd0, busy8}, 32'd1);
            if (poke) begin
                start8 = (n == 2);
                if (n == 2) begin
                    a8 = 8'hAA; b8 = 8'hAA;
                end
            end
            tick();
            n++;
        end
        start8 = 1'b0;
        chk("latency", n, 32'd8);
        chk("result", {23'd0, cout8, sum8}, {23'd0, exp_total});
        chk("busy_done", {31'd0, busy8}, 32'd1);
        pc8 = exp_total[8];
        ps8 = exp_total[7:0];
        tick();
        chk("idle_busy", {31'd0, busy8}, 32'd0);
        chk("idle_done", {31'd0, done8}, 32'd0);
    endtask

    task automatic op1(input logic xa, input logic xb);
        logic [1:0] exp_total;
        exp_total = {1'b0, xa} + {1'b0, xb};
        a1 = xa; b1 = xb; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("w1_busy_run", {31'd0, busy1}, 32'd1);
        chk("w1_no_done_yet", {31'd0, done1}, 32'd0);
        tick();
        chk("w1_done", {31'd0, done1}, 32'd1);
        chk("w1_result", {30'd0, cout1, sum1}, {30'd0, exp_total});
        tick();
        chk("w1_idle", {31'd0, busy1}, 32'd0);
    endtask

    initial begin
        int n;
        int extra;
        rst_n = 1'b0;
        start8 = 1'b0; clr8 = 1'b0; a8 = '0; b8 = '0;
        start1 = 1'b0; clr1 = 1'b0; a1 = '0; b1 = '0;
        #1;
        chk("rst_busy8", {31'd0, busy8}, 32'd0);
        chk("rst_done8", {31'd0, done8}, 32'd0);
        chk("rst_sum8", {23'd0, cout8, sum8}, 32'd0);
        chk("rst_w1", {28'd0, busy1, done1, cout1, sum1}, 32'd0);
        tick(); tick();
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Directed operand patterns, then random ones.
        op8(8'h3C, 8'h5A, 1'b0);
        op8(8'hFF, 8'h01, 1'b0);
        op8(8'h80, 8'h80, 1'b0);
        op8(8'h00, 8'h00, 1'b0);
        repeat (6) op8(8'($urandom), 8'($urandom), 1'b0);

        // Start pulsed mid-run is ignored and produces no extra done.
        op8(8'h12, 8'h34, 1'b1);
        extra = 0;
        repeat (12) begin
            tick();
            if (done8 === 1'b1) extra++;
        end
        chk("ignored_start_no_done", extra, 32'd0);

        // Start held high: back-to-back accepts every WIDTH+2 edges.
        a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
        n = 0;
        do begin tick(); n++; end while (done8 !== 1'b1 && n < 40);
        chk("held_first_latency", n, 32'd9);
        chk("held_first_sum", {23'd0, cout8, sum8}, 32'h002);
        n = 0;
        do begin
            tick(); n++;
            if (n == 4) a8 = 8'h10;
        end while (done8 !== 1'b1 && n < 40);
        chk("held_period", n, 32'd10);
        chk("held_inflight_sum", {23'd0, cout8, sum8}, 32'h002);
        n = 0;
        do begin tick(); n++; end while (done8 !== 1'b1 && n < 40);
        chk("held_period2", n, 32'd10);
        chk("held_new_sum", {23'd0, cout8, sum8}, 32'h011);
        start8 = 1'b0;
        ps8 = 8'h11; pc8 = 1'b0;
        tick();
        chk("held_released_idle", {31'd0, busy8}, 32'd0);

        // Abort at bit 4 keeps the previous result and emits no done.
        a8 = 8'h0F; b8 = 8'h01; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (4) tick();
        clr8 = 1'b1;
        tick();
        clr8 = 1'b0;
        chk("clr_busy", {31'd0, busy8}, 32'd0);
        chk("clr_done", {31'd0, done8}, 32'd0);
        chk("clr_sum_kept", {23'd0, cout8, sum8}, {23'd0, pc8, ps8});
        extra = 0;
        repeat (12) begin
            tick();
            if (done8 === 1'b1) extra++;
        end
        chk("clr_no_done", extra, 32'd0);
        clr8 = 1'b1; start8 = 1'b1;
        tick();
        clr8 = 1'b0; start8 = 1'b0;
        chk("clr_blocks_start", {31'd0, busy8}, 32'd0);
        op8(8'hC3, 8'h7E, 1'b0);

        // Asynchronous reset mid-run clears everything immediately.
        a8 = 8'h77; b8 = 8'h11; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", {31'd0, busy8}, 32'd0);
        chk("async_rst_sum", {23'd0, cout8, sum8}, 32'd0);
        ps8 = 8'h00; pc8 = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        extra = 0;
        repeat (12) begin
            tick();
            if (done8 === 1'b1 || busy8 === 1'b1) extra++;
        end
        chk("rst_discards_op", extra, 32'd0);
        op8(8'($urandom), 8'($urandom), 1'b0);

        // WIDTH=1: all four operand combinations.
        op1(1'b0, 1'b0);
        op1(1'b0, 1'b1);
        op1(1'b1, 1'b0);
        op1(1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
